// File: rtl/sb_pkg.sv
// Shared constants, index/latency types and the ID-slot bundle for the dual-issue scoreboard.
package sb_pkg;

  localparam int NREG  = 32;
  localparam int LAT_W = 3;

  typedef logic [4:0]       reg_idx_t;
  typedef logic [LAT_W-1:0] lat_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     we;
    lat_t     lat;
  } id_slot_t;

endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// Decode-to-scoreboard bundle: two ID slots in, per-slot grants and the busy map out.
interface dual_issue_scoreboard_if;
  import sb_pkg::*;

  logic     [1:0]      id_valid;
  reg_idx_t [1:0]      id_rs1;
  reg_idx_t [1:0]      id_rs2;
  reg_idx_t [1:0]      id_rd;
  logic     [1:0]      id_we;
  lat_t     [1:0]      id_lat;
  logic                issue_en;
  logic                flush;
  logic     [1:0]      issue_ok;
  logic                stall;
  logic     [NREG-1:0] busy_vec;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_we, id_lat, issue_en, flush,
    input  issue_ok, stall, busy_vec
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_lat, issue_en, flush,
    output issue_ok, stall, busy_vec
  );

endinterface

// File: rtl/sb_reg_counter.sv
// Per-register result-latency countdown; SB_FWD_EN makes cnt==1 count as ready (EX/WB bypass).
module sb_reg_counter
  import sb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic set1,
  input  logic set0,
  input  lat_t lat1,
  input  lat_t lat0,
  output lat_t cnt,
  output logic ready
);

  // Slot1 is younger, so it wins a same-bundle WAW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (set1)       cnt <= lat1;
    else if (set0)       cnt <= lat0;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

`ifdef SB_FWD_EN
  assign ready = (cnt == '0) || (cnt == lat_t'(1));
`else
  assign ready = (cnt == '0);
`endif

endmodule

// File: rtl/dual_issue_scoreboard.sv
// 2-wide in-order issue scoreboard; operand forwarding credit enabled by SB_FWD_EN.
module dual_issue_scoreboard
  import sb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  dual_issue_scoreboard_if.slave  bus
);

  id_slot_t [1:0]      slot;
  lat_t     [NREG-1:0] cnt;
  logic     [NREG-1:0] ready_vec;
  logic                gate;
  logic                raw;
  logic                ok0;
  logic                ok1;

  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      slot[i].valid = bus.id_valid[i];
      slot[i].rs1   = bus.id_rs1[i];
      slot[i].rs2   = bus.id_rs2[i];
      slot[i].rd    = bus.id_rd[i];
      slot[i].we    = bus.id_we[i];
      slot[i].lat   = bus.id_lat[i];
    end
  end

  assign cnt[0]       = '0;
  assign ready_vec[0] = 1'b1;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_reg
      sb_reg_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .set1  (ok1 & slot[1].we & (slot[1].rd == reg_idx_t'(r))),
        .set0  (ok0 & slot[0].we & (slot[0].rd == reg_idx_t'(r))),
        .lat1  (slot[1].lat),
        .lat0  (slot[0].lat),
        .cnt   (cnt[r]),
        .ready (ready_vec[r])
      );
    end
  endgenerate

  always_comb begin
    gate = bus.issue_en & ~bus.flush;
    ok0  = slot[0].valid & gate & ready_vec[slot[0].rs1] & ready_vec[slot[0].rs2];
    // Slot1 cannot consume slot0's result in the same bundle.
    raw  = slot[0].we && (slot[0].rd != '0) &&
           ((slot[1].rs1 == slot[0].rd) || (slot[1].rs2 == slot[0].rd));
    ok1  = ok0 & slot[1].valid & ready_vec[slot[1].rs1] & ready_vec[slot[1].rs2] & ~raw;
  end

  always_comb begin
    bus.issue_ok = {ok1, ok0};
    bus.stall    = slot[0].valid & gate & ~ok0;
    for (int unsigned i = 0; i < NREG; i++)
      bus.busy_vec[i] = (cnt[i] != '0);
  end

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Self-checking bench: directed scenarios pinned by literals, then random traffic against a latency-table model.
module tb_dual_issue_scoreboard;
  import sb_pkg::*;

`ifdef SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_cnt [NREG];

  dual_issue_scoreboard_if sb_if ();

  dual_issue_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rdy(input int s);
    return (s == 0) || (m_cnt[s] == 0) || (FWD && m_cnt[s] == 1);
  endfunction

  task automatic set_slot(input int i, input bit v, input int rs1, input int rs2,
                          input int rd, input bit we, input int lat);
    sb_if.id_valid[i] = v;
    sb_if.id_rs1[i]   = reg_idx_t'(rs1);
    sb_if.id_rs2[i]   = reg_idx_t'(rs2);
    sb_if.id_rd[i]    = reg_idx_t'(rd);
    sb_if.id_we[i]    = we;
    sb_if.id_lat[i]   = lat_t'(lat);
  endtask

  task automatic idle();
    set_slot(0, 0, 0, 0, 0, 0, 0);
    set_slot(1, 0, 0, 0, 0, 0, 0);
    sb_if.issue_en = 1'b1;
    sb_if.flush    = 1'b0;
  endtask

  // One cycle: compare outputs against the model, then advance the model at the clock edge.
  task automatic step();
    bit gate, ok0, ok1, raw;
    logic [NREG-1:0] busy;
    int rd0, rd1;
    #1;
    gate = sb_if.issue_en && !sb_if.flush;
    rd0  = int'(sb_if.id_rd[0]);
    rd1  = int'(sb_if.id_rd[1]);
    ok0  = sb_if.id_valid[0] && gate && rdy(int'(sb_if.id_rs1[0])) && rdy(int'(sb_if.id_rs2[0]));
    raw  = sb_if.id_we[0] && rd0 != 0 &&
           (int'(sb_if.id_rs1[1]) == rd0 || int'(sb_if.id_rs2[1]) == rd0);
    ok1  = ok0 && sb_if.id_valid[1] && rdy(int'(sb_if.id_rs1[1])) &&
           rdy(int'(sb_if.id_rs2[1])) && !raw;
    for (int i = 0; i < NREG; i++) busy[i] = (m_cnt[i] != 0);
    chk("issue_ok", 32'(sb_if.issue_ok), 32'({ok1, ok0}));
    chk("stall", 32'(sb_if.stall), 32'(sb_if.id_valid[0] && gate && !ok0));
    chk("busy_vec", sb_if.busy_vec, busy);
    @(posedge clk);
    for (int i = 1; i < NREG; i++) begin
      if (ok1 && sb_if.id_we[1] && rd1 == i)      m_cnt[i] = int'(sb_if.id_lat[1]);
      else if (ok0 && sb_if.id_we[0] && rd0 == i) m_cnt[i] = int'(sb_if.id_lat[0]);
      else if (m_cnt[i] > 0)                      m_cnt[i] = m_cnt[i] - 1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
    idle();
    set_slot(0, 1, 1, 2, 5, 1, 1);
    set_slot(1, 1, 3, 4, 6, 1, 1);
    #12;
    chk("reset_issue_ok", 32'(sb_if.issue_ok), 32'h3);
    chk("reset_stall", 32'(sb_if.stall), 32'h0);
    chk("reset_busy", sb_if.busy_vec, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two independent ALU ops.
    #1 chk("pair_ok", 32'(sb_if.issue_ok), 32'h3);
    step();
    idle();
    #1 chk("pair_busy", sb_if.busy_vec, 32'h0000_0060);
    step();
    #1 chk("pair_clear", sb_if.busy_vec, 32'h0);
    step();

    // Intra-bundle RAW on x5.
    set_slot(0, 1, 1, 2, 5, 1, 1);
    set_slot(1, 1, 5, 3, 8, 1, 1);
    #1 chk("raw_ok", 32'(sb_if.issue_ok), 32'h1);
    step();
    set_slot(0, 1, 5, 3, 8, 1, 1);
    set_slot(1, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_next_ok", 32'(sb_if.issue_ok), FWD ? 32'h1 : 32'h0);
    chk("raw_next_stall", 32'(sb_if.stall), FWD ? 32'h0 : 32'h1);
    step();
    if (!FWD) begin
      #1 chk("raw_late_ok", 32'(sb_if.issue_ok), 32'h1);
      step();
    end
    idle();
    repeat (3) step();

    // Load x7 (lat 2) followed by a dependent add.
    set_slot(0, 1, 0, 0, 7, 1, 2);
    step();
    set_slot(0, 1, 7, 0, 10, 1, 1);
    #1 chk("load_stall1", 32'(sb_if.stall), 32'h1);
    chk("load_busy7", 32'(sb_if.busy_vec[7]), 32'h1);
    step();
    #1 chk("load_stall2", 32'(sb_if.stall), FWD ? 32'h0 : 32'h1);
    step();
    if (FWD) idle();
    #1 chk("load_busy7_clear", 32'(sb_if.busy_vec[7]), 32'h0);
    chk("load_stall3", 32'(sb_if.stall), 32'h0);
    step();
    idle();
    repeat (2) step();

    // Same-bundle WAW on x9: slot1's latency wins.
    set_slot(0, 1, 0, 0, 9, 1, 3);
    set_slot(1, 1, 0, 0, 9, 1, 1);
    #1 chk("waw_ok", 32'(sb_if.issue_ok), 32'h3);
    step();
    idle();
    #1 chk("waw_busy9", 32'(sb_if.busy_vec[9]), 32'h1);
    step();
    #1 chk("waw_clear9", 32'(sb_if.busy_vec[9]), 32'h0);
    step();
    repeat (2) step();

    // Writes to x0 are never tracked.
    set_slot(0, 1, 0, 0, 0, 1, 5);
    set_slot(1, 1, 0, 0, 0, 1, 5);
    step();
    set_slot(0, 1, 0, 0, 11, 1, 1);
    set_slot(1, 1, 0, 0, 12, 1, 1);
    #1 chk("x0_busy", sb_if.busy_vec, 32'h0);
    chk("x0_ok", 32'(sb_if.issue_ok), 32'h3);
    step();
    idle();
    repeat (2) step();

    // Flush / issue_en=0 while x4 counts down from 3.
    set_slot(0, 1, 0, 0, 4, 1, 3);
    step();
    set_slot(0, 1, 1, 2, 13, 1, 1);
    sb_if.flush = 1'b1;
    #1 chk("flush_ok", 32'(sb_if.issue_ok), 32'h0);
    chk("flush_stall", 32'(sb_if.stall), 32'h0);
    chk("flush_busy4", 32'(sb_if.busy_vec[4]), 32'h1);
    step();
    sb_if.flush = 1'b0;
    sb_if.issue_en = 1'b0;
    #1 chk("hold_ok", 32'(sb_if.issue_ok), 32'h0);
    step();
    idle();
    #1 chk("x4_busy_cnt1", 32'(sb_if.busy_vec[4]), 32'h1);
    step();
    #1 chk("x4_clear", 32'(sb_if.busy_vec[4]), 32'h0);
    step();

    // Asynchronous reset mid-count.
    set_slot(0, 1, 0, 0, 4, 1, 7);
    step();
    idle();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_busy", sb_if.busy_vec, 32'h0);
    for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      for (int s = 0; s < 2; s++)
        set_slot(s, ($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), ($urandom_range(0, 3) != 0), $urandom_range(0, 7));
      sb_if.issue_en = ($urandom_range(0, 9) != 0);
      sb_if.flush    = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
